keypad_scanner: RTL



---
 rtl/keypad_scanner.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-scan debounce.
// Emits a one-cycle KeyValid per accepted press and a held level.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic [3:0] Key,
  output logic       KeyValid,
  output logic       KeyHeld
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] TC = PW'(SCAN_DIV - 1);
  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE, PRESS_DEB, HELD, RELEASE_DEB
  } state_t;

  logic [3:0]    col_m, col_s;
  logic [PW-1:0] presc;
  logic [1:0]    row_idx, row_nx;
  logic          tick, scan_done;

  // pressed-position count for the scan so far, saturating at 2
  logic [1:0] acc_q, acc_n;
  logic [3:0] code_q, code_n;
  logic [2:0] row_cnt, sum;
  logic [1:0] col_enc;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0] cand_q, cand_d;
  logic [3:0] key_d;
  logic       valid_q, valid_d;
  logic       held_d;
  logic       res_none, res_key;

  assign tick      = (presc == TC);
  assign scan_done = tick && (row_idx == 2'd3);
  assign row_nx    = row_idx + 2'd1;

  always_comb begin
    row_cnt = 3'd0;
    col_enc = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s[i]) begin
        row_cnt = row_cnt + 3'd1;
        col_enc = 2'(i);
      end
    end
    sum    = {1'b0, acc_q} + row_cnt;
    acc_n  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    code_n = code_q;
    if (acc_q == 2'd0 && row_cnt == 3'd1)
      code_n = {row_idx, col_enc};
  end

  assign res_none = (acc_n == 2'd0);
  assign res_key  = (acc_n == 2'd1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      col_m   <= 4'hF;
      col_s   <= 4'hF;
      presc   <= '0;
      row_idx <= 2'd0;
      Row     <= 4'b1110;
      acc_q   <= 2'd0;
      code_q  <= 4'd0;
    end else begin
      col_m <= Col;
      col_s <= col_m;
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        row_idx <= row_nx;
        Row     <= ~(4'b0001 << row_nx);
      end
      if (scan_done) begin
        acc_q  <= 2'd0;
        code_q <= 4'd0;
      end else if (tick) begin
        acc_q  <= acc_n;
        code_q <= code_n;
      end
    end
  end

  assign cnt_inc = (cnt_q >= DS) ? DS : cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    key_d   = Key;
    valid_d = 1'b0;
    held_d  = KeyHeld;
    if (scan_done) begin
      unique case (state_q)
        IDLE: begin
          if (res_key) begin
            cand_d  = code_n;
            cnt_d   = 4'd1;
            state_d = PRESS_DEB;
          end
        end
        PRESS_DEB: begin
          if (res_key && code_n == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS) begin
              key_d   = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = HELD;
            end
          end else if (res_key) begin
            cand_d = code_n;
            cnt_d  = 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (res_none) begin
            cnt_d   = 4'd1;
            state_d = RELEASE_DEB;
          end
        end
        RELEASE_DEB: begin
          if (res_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS) begin
              held_d  = 1'b0;
              state_d = IDLE;
            end
          end else begin
            state_d = HELD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      cand_q  <= 4'd0;
      Key     <= 4'd0;
      valid_q <= 1'b0;
      KeyHeld <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      Key     <= key_d;
      valid_q <= valid_d;
      KeyHeld <= held_d;
    end
  end

  // the strobe is masked combinationally so it can never coincide with Reset
  assign KeyValid = valid_q && !Reset;

endmodule
